led_sequencer: RTL and testbench
================================

# led_sequencer

Parametrised multi-mode LED pattern generator and successor to the single-pattern 1 Hz rotating-LED block. It sits downstream of the board clock divider, runs on the divided clock `clk1h`, and drives an active-low LED bank. Pattern width, step rate, direction and pattern mode are all runtime or elaboration selectable, and a wrap pulse marks pattern-cycle completion.

## Interface
- `WIDTH`, 8: LED count; legal range 2..32.
- `DIV_W`, 4: width of the step-rate divider field.
- `clk1h`  in  1: step-base clock from the divider.
- `rst`  in  1: asynchronous, active-low reset.
- `en`  in  1: advance enable; low freezes all state.
- `mode`  in  3: pattern select. 0 ROT, 1 BOUNCE, 2 FILL, 3 BLINK, 4 COUNT; 5..7 behave as ROT.
- `dir`  in  1: 0 rotates right / counts up, 1 rotates left / counts down. Used by ROT and COUNT only.
- `step_div`  in  DIV_W: the pattern advances once every `step_div`+1 enabled clocks.
- `led`  out  WIDTH: LED drive, active-low (0 = lit), registered.
- `wrap`  out  1: one-cycle registered pulse on the step that returns the pattern to its start state.

## Operation
- Internal lit-pattern `pat` (1 = lit); `led` = ~`pat`, registered.
- State: `mode_q`, position `pos` (0..WIDTH-1), fill count `n` (0..WIDTH), phase bit `ph`, WIDTH-bit count `cnt`, divider `div`.
- Reset: `mode_q`=0, `pos`=0, `n`=0, `ph`=0, `cnt`=0, `div`=0, `wrap`=0. `led` = all ones except bit0 = 0, which is 8'b1111_1110 at the default width.
- Step condition: `en`=1 and `div`==`step_div`. On a step, `div` returns to 0. Otherwise, when `en`=1, `div` increments. When `en`=0, `div` and everything else hold.
- ROT: `pat`=1<<`pos`.
  - `dir`=0: `pos` decrements mod WIDTH, so 0 goes to WIDTH-1.
  - `dir`=1: `pos` increments mod WIDTH.
  - Start state `pos`=0.
- BOUNCE: `pat`=1<<`pos`.
  - `ph`=0: `pos` increments. `ph`=1: `pos` decrements.
  - On reaching WIDTH-1 or 0, `ph` flips in the same step, so the end LED is shown for exactly one step.
  - Start state `pos`=0, `ph`=0. Full cycle is 2·WIDTH-2 steps.
- FILL: `pat` = low `n` bits set. `n` goes 0,1,…,WIDTH,0. Start state `n`=0, all LEDs off.
- BLINK: `ph`=0 means all lit, `ph`=1 means all off. Each step toggles `ph`. Start state `ph`=0.
- COUNT: `pat`=`cnt`. `cnt` increments (`dir`=0) or decrements (`dir`=1) mod 2^WIDTH. Start state `cnt`=0.
- Mode change: when `mode`≠`mode_q` on any clock, regardless of `en`:
  - `mode_q` loads `mode`; `pos`, `n`, `ph`, `cnt` and `div` clear.
  - `led` loads the new mode's start pattern.
  - Mode change takes priority over a coincident step.
  - `wrap` = 0 on that clock.
  - A change between modes 0 and 5..7 still restarts the pattern.
- `wrap`: asserted for one clock, aligned with the `led` update, when a step enters the start state. Not asserted at reset or on a mode-change restart.
- A `dir` change takes effect on the next step with no restart.
- A `step_div` change takes effect immediately. If `div` is already greater than the new `step_div`, `div` counts up to 2^DIV_W-1, wraps to 0, and then matches.

## Timing
- Single clock domain `clk1h`; all outputs are registered.
- With `step_div`=k, the `led` update occurs on the (k+1)th enabled rising edge after the previous step.
- Mode-change latency: 1 clock from the sampled `mode` to the new start pattern on `led`.
- Reset is asynchronous assert; release is synchronised externally. Reset mid-pattern returns to the ROT start state immediately.

## Structure
- Package `led_seq_pkg` holds the mode encodings (MODE_ROT, MODE_BOUNCE, MODE_FILL, MODE_BLINK, MODE_COUNT) and the mode field width of 3.
- Sub-module `step_prescaler` holds `div` and produces the `step` strobe, with inputs `en`, `step_div` and a synchronous `clear`.
- The top level contains the mode register, the per-mode next-state logic, the pattern mux and the output registers.

## Test plan
- Reset, then mode=0, dir=0, step_div=0, en=1 → `led` goes 1111_1110, then 0111_1111, then 1011_1111. `wrap` pulses on step 8, when `led` returns to 1111_1110.
- mode=1, step_div=0, WIDTH=8 → `pos` sequence 0..7..0 over 14 steps. `led`=0111_1111 appears exactly once per cycle. `wrap` pulses on step 14 only.
- mode=2, step_div=2 → `led` steps every 3 clocks through 1111_1111, 1111_1110, …, 0000_0000, 1111_1111. `wrap` pulses with the final step.
- mode=4, dir=1, from start → `led` goes to 0000_0000 (`cnt`=0xFF) on step 1, then 0000_0001 on step 2. Hold en=0 for 5 clocks → `led` unchanged.
- Mid-ROT at pos=5, switch mode to 3 on a clock that coincides with a step → the next `led` is 0000_0000 (all lit) and `wrap`=0. Then `led` alternates with 1111_1111 each step.
- Assert rst mid-BOUNCE with `ph`=1 → `led` becomes 1111_1110 asynchronously and `wrap`=0. After release with mode=1 held, a restart occurs 1 clock later.

Source files
------------

// File: rtl/led_sequencer_pkg.sv
// led_seq_pkg: mode encodings and helpers shared by the LED sequencer slice
package led_seq_pkg;
  localparam int MODE_W = 3;
  typedef enum logic [MODE_W-1:0] {
    MODE_ROT    = 3'd0,
    MODE_BOUNCE = 3'd1,
    MODE_FILL   = 3'd2,
    MODE_BLINK  = 3'd3,
    MODE_COUNT  = 3'd4
  } mode_e;
  // Encodings above MODE_COUNT run the rotate pattern
  function automatic mode_e eff_mode(input logic [MODE_W-1:0] m);
    return (m > MODE_W'(4)) ? MODE_ROT : mode_e'(m);
  endfunction
endpackage

// File: rtl/led_sequencer_if.sv
// led_sequencer_if: control inputs and LED outputs of the sequencer
interface led_sequencer_if
  import led_seq_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIV_W = 4
);
  logic              i_en;
  logic [MODE_W-1:0] i_mode;
  logic              i_dir;
  logic [DIV_W-1:0]  i_step_div;
  logic [WIDTH-1:0]  o_led;
  logic              o_wrap;
  modport master (output i_en, i_mode, i_dir, i_step_div, input o_led, o_wrap);
  modport slave (input i_en, i_mode, i_dir, i_step_div, output o_led, o_wrap);
endinterface

// File: rtl/led_sequencer_step_prescaler.sv
// step_prescaler: counts enabled clocks and strobes a step every step_div+1 of them
module step_prescaler #(
  parameter int DIV_W = 4
) (
  input  logic             clk1h,
  input  logic             rst,
  input  logic             i_en,
  input  logic [DIV_W-1:0] i_step_div,
  input  logic             i_clear,
  output logic             o_step
);
  logic [DIV_W-1:0] r_div;
  assign o_step = i_en && !i_clear && (r_div == i_step_div);
  // A div already past a lowered step_div wraps through zero before matching
  always_ff @(posedge clk1h or negedge rst) begin
    if (!rst) r_div <= '0;
    else if (i_clear) r_div <= '0;
    else if (i_en) r_div <= o_step ? '0 : r_div + DIV_W'(1);
  end
endmodule

// File: rtl/led_sequencer.sv
// led_sequencer: multi-mode active-low LED pattern generator with wrap pulse
module led_sequencer
  import led_seq_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIV_W = 4
) (
  input logic             clk1h,
  input logic             rst,
  led_sequencer_if.slave  bus
);
  localparam int PW = $clog2(WIDTH);
  localparam int NW = $clog2(WIDTH + 1);
  localparam logic [PW-1:0] P_MAX = PW'(WIDTH - 1);
  localparam logic [NW-1:0] N_MAX = NW'(WIDTH);
  logic [MODE_W-1:0] r_mode_q;
  logic [PW-1:0]     r_pos, w_pos;
  logic [NW-1:0]     r_n, w_n;
  logic              r_ph, w_ph;
  logic [WIDTH-1:0]  r_cnt, w_cnt, w_pat, w_start, r_led;
  logic              r_wrap, w_wrap, w_chg, w_step;
  mode_e             w_mode, w_new_mode;
  assign w_chg      = bus.i_mode != r_mode_q;
  assign w_mode     = eff_mode(r_mode_q);
  assign w_new_mode = eff_mode(bus.i_mode);
  step_prescaler #(.DIV_W(DIV_W)) u_pre (
    .clk1h      (clk1h),
    .rst        (rst),
    .i_en       (bus.i_en),
    .i_step_div (bus.i_step_div),
    .i_clear    (w_chg),
    .o_step     (w_step)
  );
  // Candidate next state and its lit pattern; committed only on a step
  always_comb begin
    w_pos  = r_pos;
    w_n    = r_n;
    w_ph   = r_ph;
    w_cnt  = r_cnt;
    w_pat  = '0;
    w_wrap = 1'b0;
    case (w_mode)
      MODE_BOUNCE: begin
        w_pos  = r_ph ? r_pos - PW'(1) : r_pos + PW'(1);
        w_ph   = (w_pos == P_MAX || w_pos == '0) ? ~r_ph : r_ph;
        w_pat  = WIDTH'(1) << w_pos;
        w_wrap = r_ph && (w_pos == '0);
      end
      MODE_FILL: begin
        w_n    = (r_n == N_MAX) ? '0 : r_n + NW'(1);
        w_pat  = ~({WIDTH{1'b1}} << w_n);
        w_wrap = w_n == '0;
      end
      MODE_BLINK: begin
        w_ph   = ~r_ph;
        w_pat  = {WIDTH{r_ph}};
        w_wrap = r_ph;
      end
      MODE_COUNT: begin
        w_cnt  = bus.i_dir ? r_cnt - WIDTH'(1) : r_cnt + WIDTH'(1);
        w_pat  = w_cnt;
        w_wrap = w_cnt == '0;
      end
      default: begin
        w_pos  = bus.i_dir ? ((r_pos == P_MAX) ? '0 : r_pos + PW'(1))
                           : ((r_pos == '0) ? P_MAX : r_pos - PW'(1));
        w_pat  = WIDTH'(1) << w_pos;
        w_wrap = w_pos == '0;
      end
    endcase
  end
  assign w_start = (w_new_mode == MODE_ROT || w_new_mode == MODE_BOUNCE) ? ~WIDTH'(1) :
                   (w_new_mode == MODE_BLINK) ? '0 : '1;
  always_ff @(posedge clk1h or negedge rst) begin
    if (!rst) begin
      r_mode_q <= '0;
      r_pos    <= '0;
      r_n      <= '0;
      r_ph     <= 1'b0;
      r_cnt    <= '0;
      r_led    <= ~WIDTH'(1);
      r_wrap   <= 1'b0;
    end else if (w_chg) begin
      r_mode_q <= bus.i_mode;
      r_pos    <= '0;
      r_n      <= '0;
      r_ph     <= 1'b0;
      r_cnt    <= '0;
      r_led    <= w_start;
      r_wrap   <= 1'b0;
    end else begin
      r_wrap <= w_step && w_wrap;
      if (w_step) begin
        r_pos <= w_pos;
        r_n   <= w_n;
        r_ph  <= w_ph;
        r_cnt <= w_cnt;
        r_led <= ~w_pat;
      end
    end
  end
  assign bus.o_led  = r_led;
  assign bus.o_wrap = r_wrap;
endmodule

// File: tb/tb_led_sequencer.sv
// tb_led_sequencer: directed and randomized checks against a step-index reference model
module tb_led_sequencer;
  localparam int W  = 8;
  localparam int DW = 4;
  logic clk1h = 1'b0;
  logic rst   = 1'b0;
  int checks = 0;
  int failures = 0;
  led_sequencer_if #(.WIDTH(W), .DIV_W(DW)) bus ();
  led_sequencer #(.WIDTH(W), .DIV_W(DW)) dut (.clk1h(clk1h), .rst(rst), .bus(bus));
  always #5 clk1h = ~clk1h;

  int m_mode, m_pos, m_idx, m_div;
  longint m_cnt;
  logic [W-1:0] m_led;
  logic m_wrap;

  function automatic int eff(input int m);
    return (m > 4) ? 0 : m;
  endfunction

  function automatic logic [W-1:0] lit_pattern();
    longint p;
    case (eff(m_mode))
      1: p = longint'(1) << ((m_idx < W) ? m_idx : 2 * W - 2 - m_idx);
      2: p = (longint'(1) << m_idx) - 1;
      3: p = (m_idx == 0) ? (longint'(1) << W) - 1 : 0;
      4: p = m_cnt;
      default: p = longint'(1) << m_pos;
    endcase
    return W'(p);
  endfunction

  task automatic model_reset();
    m_mode = 0; m_pos = 0; m_idx = 0; m_div = 0; m_cnt = 0; m_wrap = 1'b0;
    m_led = ~lit_pattern();
  endtask

  task automatic model_clock();
    bit at_start;
    if (int'(bus.i_mode) != m_mode) begin
      m_mode = int'(bus.i_mode); m_pos = 0; m_idx = 0; m_div = 0; m_cnt = 0;
      m_wrap = 1'b0;
      m_led = ~lit_pattern();
    end else if (!bus.i_en) begin
      m_wrap = 1'b0;
    end else if (m_div != int'(bus.i_step_div)) begin
      m_div = (m_div + 1) % (1 << DW);
      m_wrap = 1'b0;
    end else begin
      m_div = 0;
      case (eff(m_mode))
        1: begin m_idx = (m_idx + 1) % (2 * W - 2); at_start = m_idx == 0; end
        2: begin m_idx = (m_idx + 1) % (W + 1); at_start = m_idx == 0; end
        3: begin m_idx = (m_idx + 1) % 2; at_start = m_idx == 0; end
        4: begin
          m_cnt = (m_cnt + (bus.i_dir ? (longint'(1) << W) - 1 : 1)) % (longint'(1) << W);
          at_start = m_cnt == 0;
        end
        default: begin
          m_pos = bus.i_dir ? (m_pos + 1) % W : (m_pos + W - 1) % W;
          at_start = m_pos == 0;
        end
      endcase
      m_led = ~lit_pattern();
      m_wrap = at_start;
    end
  endtask

  task automatic tick();
    model_clock();
    @(posedge clk1h);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    model_reset();
    #2;
    rst = 1'b1;
  endtask

  task automatic set_in(input logic en, input int mode, input logic dir, input int sd);
    bus.i_en = en;
    bus.i_mode = 3'(mode);
    bus.i_dir = dir;
    bus.i_step_div = DW'(sd);
  endtask

  task automatic test_reset();
    set_in(1'b0, 0, 1'b0, 0);
    do_reset();
    if (bus.o_led !== 8'hFE || bus.o_wrap !== 1'b0) begin
      failures++;
      $display("FAIL reset led=%b wrap=%b expected led=11111110 wrap=0", bus.o_led, bus.o_wrap);
    end
    checks++;
  endtask

  task automatic test_rot();
    logic [W-1:0] exp_seq [8] = '{8'h7F, 8'hBF, 8'hDF, 8'hEF, 8'hF7, 8'hFB, 8'hFD, 8'hFE};
    do_reset();
    set_in(1'b1, 0, 1'b0, 0);
    for (int i = 0; i < 8; i++) begin
      tick();
      if (bus.o_led !== exp_seq[i] || bus.o_wrap !== (i == 7) || bus.o_led !== m_led) begin
        failures++;
        $display("FAIL rot step %0d led=%b wrap=%b expected led=%b wrap=%0d", i + 1, bus.o_led, bus.o_wrap, exp_seq[i], i == 7);
      end
      checks++;
    end
  endtask

  task automatic test_bounce();
    int end_seen = 0;
    int wraps = 0;
    do_reset();
    set_in(1'b1, 1, 1'b0, 0);
    tick();
    for (int i = 0; i < 28; i++) begin
      tick();
      if (bus.o_led === 8'h7F) end_seen++;
      if (bus.o_wrap === 1'b1) wraps++;
      if (bus.o_led !== m_led || bus.o_wrap !== m_wrap) begin
        failures++;
        $display("FAIL bounce step %0d led=%b wrap=%b expected led=%b wrap=%b", i + 1, bus.o_led, bus.o_wrap, m_led, m_wrap);
      end
      checks++;
    end
    if (end_seen != 2 || wraps != 2) begin
      failures++;
      $display("FAIL bounce_cycle end_led=%0d wraps=%0d expected 2 and 2", end_seen, wraps);
    end
    checks++;
  endtask

  task automatic test_fill();
    int wraps = 0;
    do_reset();
    set_in(1'b1, 2, 1'b0, 2);
    tick();
    if (bus.o_led !== 8'hFF) begin
      failures++;
      $display("FAIL fill_start led=%b expected 11111111", bus.o_led);
    end
    checks++;
    for (int i = 0; i < 27; i++) begin
      tick();
      if (bus.o_wrap === 1'b1) wraps++;
      if (bus.o_led !== m_led || bus.o_wrap !== m_wrap) begin
        failures++;
        $display("FAIL fill clock %0d led=%b wrap=%b expected led=%b wrap=%b", i + 1, bus.o_led, bus.o_wrap, m_led, m_wrap);
      end
      checks++;
    end
    if (wraps != 1 || bus.o_led !== 8'hFF) begin
      failures++;
      $display("FAIL fill_cycle wraps=%0d led=%b expected 1 and 11111111", wraps, bus.o_led);
    end
    checks++;
  endtask

  task automatic test_count_hold();
    logic [W-1:0] held;
    do_reset();
    set_in(1'b1, 4, 1'b1, 0);
    tick();
    tick();
    if (bus.o_led !== 8'h00) begin
      failures++;
      $display("FAIL count_down1 led=%b expected 00000000", bus.o_led);
    end
    checks++;
    tick();
    if (bus.o_led !== 8'h01) begin
      failures++;
      $display("FAIL count_down2 led=%b expected 00000001", bus.o_led);
    end
    checks++;
    held = m_led;
    bus.i_en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (bus.o_led !== held || bus.o_wrap !== 1'b0) begin
        failures++;
        $display("FAIL hold clock %0d led=%b wrap=%b expected led=%b wrap=0", i, bus.o_led, bus.o_wrap, held);
      end
      checks++;
    end
  endtask

  task automatic test_mode_change();
    logic [W-1:0] exp_seq [4] = '{8'h00, 8'hFF, 8'h00, 8'hFF};
    do_reset();
    set_in(1'b1, 0, 1'b0, 0);
    repeat (3) tick();
    if (bus.o_led !== 8'hDF) begin
      failures++;
      $display("FAIL rot_pos5 led=%b expected 11011111", bus.o_led);
    end
    checks++;
    bus.i_mode = 3'd3;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (bus.o_led !== exp_seq[i] || bus.o_wrap !== (i == 2)) begin
        failures++;
        $display("FAIL blink step %0d led=%b wrap=%b expected led=%b wrap=%0d", i, bus.o_led, bus.o_wrap, exp_seq[i], i == 2);
      end
      checks++;
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    set_in(1'b1, 1, 1'b0, 0);
    repeat (11) tick();
    #2;
    rst = 1'b0;
    model_reset();
    #1;
    if (bus.o_led !== 8'hFE || bus.o_wrap !== 1'b0) begin
      failures++;
      $display("FAIL async_reset led=%b wrap=%b expected led=11111110 wrap=0", bus.o_led, bus.o_wrap);
    end
    checks++;
    #2;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (bus.o_led !== m_led || bus.o_wrap !== m_wrap) begin
        failures++;
        $display("FAIL post_reset clock %0d led=%b wrap=%b expected led=%b wrap=%b", i, bus.o_led, bus.o_wrap, m_led, m_wrap);
      end
      checks++;
    end
  endtask

  task automatic test_random();
    do_reset();
    set_in(1'b1, 0, 1'b0, 0);
    for (int i = 0; i < 600; i++) begin
      bus.i_en = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 39) == 0) bus.i_mode = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 15) == 0) bus.i_dir = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 29) == 0) bus.i_step_div = DW'($urandom_range(0, 3));
      tick();
      if (bus.o_led !== m_led || bus.o_wrap !== m_wrap) begin
        failures++;
        $display("FAIL random clock %0d led=%b wrap=%b expected led=%b wrap=%b", i, bus.o_led, bus.o_wrap, m_led, m_wrap);
      end
      checks++;
    end
  endtask

  initial begin
    set_in(1'b0, 0, 1'b0, 0);
    @(posedge clk1h);
    #1;
    test_reset();
    test_rot();
    test_bounce();
    test_fill();
    test_count_hold();
    test_mode_change();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
